wave_analyzer_mc: RTL and testbench

//  Parametrised multi-channel successor to the wave_analyzer_low/high pair.
//  Per channel, measures the signal period in clk cycles and the peak amplitude
//  of a signed sample stream, e.g. lft_inverse/rght_inverse from PDM_decoder.

---
 rtl/wave_analyzer_mc.sv | 183 ++++++++++++++++++
 tb/tb_wave_analyzer_mc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wave_analyzer_mc.sv
// Multi-channel period and peak-amplitude analyzer for signed sample streams.
// Each channel has a hysteresis sign tracker, a crossing-driven FSM, period averaging and a timeout.
module wave_analyzer_mc #(
    parameter int NCH      = 2,
    parameter int DW       = 16,
    parameter int PW       = 22,
    parameter int AW       = 12,
    parameter int HYST     = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] smpl,
    input  logic              clr,
    output logic [NCH*PW-1:0] per,
    output logic [NCH*AW-1:0] amp,
    output logic [NCH-1:0]    vld,
    output logic [NCH-1:0]    tmo
);

    localparam int ACCW = PW + AVG_LOG2;
    localparam int NW   = AVG_LOG2 + 1;
    localparam int NAVG = 1 << AVG_LOG2;
    localparam int SH   = DW - 1 - AW;

    localparam logic [NW-1:0]        NPER_LAST = NW'(NAVG - 1);
    localparam logic [PW-1:0]        CNT_MAX   = '1;
    localparam logic signed [DW-1:0] HYST_P    = DW'(HYST);
    localparam logic signed [DW-1:0] HYST_N    = DW'(-HYST);
    localparam logic signed [DW-1:0] SMPL_MIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {TRK_NONE, TRK_POS, TRK_NEG} trk_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS} state_t;

    // Magnitude of a sample; the most negative code saturates to the largest positive one.
    function automatic logic [DW-2:0] abs_sat(input logic signed [DW-1:0] x);
        if (x == SMPL_MIN)
            return '1;
        else if (x[DW-1])
            return (DW-1)'(-x);
        else
            return x[DW-2:0];
    endfunction

    function automatic logic [AW-1:0] scale_amp(input logic [DW-2:0] p);
        return AW'(p >> SH);
    endfunction

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic signed [DW-1:0] x;
        logic [DW-2:0]        ax;
        logic                 rise;

        trk_t            trk_q, trk_d;
        state_t          state_q, state_d;
        logic [PW-1:0]   cnt_q, cnt_d;
        logic [ACCW-1:0] acc_q, acc_d;
        logic [NW-1:0]   nper_q, nper_d;
        logic [DW-2:0]   pk_q, pk_d;
        logic [DW-2:0]   pk_max;
        logic [ACCW-1:0] sum;
        logic [PW-1:0]   per_q, per_d;
        logic [AW-1:0]   amp_q, amp_d;
        logic            vld_q, vld_d;
        logic            tmo_q, tmo_d;

        assign x  = smpl[k*DW +: DW];
        assign ax = abs_sat(x);

        always_comb begin
            trk_d = trk_q;
            if (x >= HYST_P)
                trk_d = TRK_POS;
            else if (x <= HYST_N)
                trk_d = TRK_NEG;
        end

        // Only NEG->POS counts; a tracker leaving NONE never produces a crossing.
        assign rise = (trk_q == TRK_NEG) && (trk_d == TRK_POS);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            acc_d   = acc_q;
            nper_d  = nper_q;
            pk_d    = pk_q;
            per_d   = per_q;
            amp_d   = amp_q;
            vld_d   = 1'b0;
            tmo_d   = tmo_q;
            pk_max  = (ax > pk_q) ? ax : pk_q;
            sum     = acc_q + ACCW'(cnt_q);

            case (state_q)
                ST_IDLE: begin
                    if (trk_q == TRK_NEG)
                        state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_MEAS;
                        cnt_d   = PW'(1);
                        acc_d   = '0;
                        nper_d  = '0;
                        pk_d    = ax;
                    end
                end
                ST_MEAS: begin
                    if (cnt_q == CNT_MAX) begin
                        per_d   = CNT_MAX;
                        amp_d   = scale_amp(pk_max);
                        vld_d   = 1'b1;
                        tmo_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rise) begin
                        // The crossing sample already belongs to the next period.
                        cnt_d = PW'(1);
                        if (nper_q == NPER_LAST) begin
                            per_d  = PW'(sum >> AVG_LOG2);
                            amp_d  = scale_amp(pk_q);
                            vld_d  = 1'b1;
                            tmo_d  = 1'b0;
                            acc_d  = '0;
                            nper_d = '0;
                            pk_d   = ax;
                        end else begin
                            acc_d  = sum;
                            nper_d = nper_q + NW'(1);
                            pk_d   = pk_max;
                        end
                    end else begin
                        cnt_d = cnt_q + PW'(1);
                        pk_d  = pk_max;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                trk_q   <= TRK_NONE;
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                acc_q   <= '0;
                nper_q  <= '0;
                pk_q    <= '0;
                per_q   <= '0;
                amp_q   <= '0;
                vld_q   <= 1'b0;
                tmo_q   <= 1'b0;
            end else if (clr) begin
                trk_q   <= TRK_NONE;
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                acc_q   <= '0;
                nper_q  <= '0;
                pk_q    <= '0;
                per_q   <= '0;
                amp_q   <= '0;
                vld_q   <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                trk_q   <= trk_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                acc_q   <= acc_d;
                nper_q  <= nper_d;
                pk_q    <= pk_d;
                per_q   <= per_d;
                amp_q   <= amp_d;
                vld_q   <= vld_d;
                tmo_q   <= tmo_d;
            end
        end

        assign per[k*PW +: PW] = per_q;
        assign amp[k*AW +: AW] = amp_q;
        assign vld[k]          = vld_q;
        assign tmo[k]          = tmo_q;
    end

endmodule

// File: tb/tb_wave_analyzer_mc.sv
// Directed scoreboard bench for wave_analyzer_mc: expected strobes are queued as stimulus is
// driven and matched (cycle, period, amplitude, timeout flag) whenever a channel strobes.
module tb_wave_analyzer_mc;
    localparam int NCH = 2, DW = 16, PW = 12, AW = 11, HYST = 16, AVG_LOG2 = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*DW-1:0] smpl;
    logic              clr;
    logic [NCH*PW-1:0] per;
    logic [NCH*AW-1:0] amp;
    logic [NCH-1:0]    vld;
    logic [NCH-1:0]    tmo;

    wave_analyzer_mc #(.NCH(NCH), .DW(DW), .PW(PW), .AW(AW), .HYST(HYST), .AVG_LOG2(AVG_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .smpl(smpl), .clr(clr),
        .per(per), .amp(amp), .vld(vld), .tmo(tmo)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int per; int amp; int tmo; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Scoreboard side: every strobe must have been predicted, at the predicted cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && vld[0] === 1'b1) begin
            chk("vld0_predicted", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("vld0_cycle", cyc, e0.cyc);
                chk("per0", per[0 +: PW], e0.per);
                chk("amp0", amp[0 +: AW], e0.amp);
                chk("tmo0", tmo[0], e0.tmo);
            end
        end
        if (rst_n === 1'b1 && vld[1] === 1'b1) begin
            chk("vld1_predicted", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("vld1_cycle", cyc, e1.cyc);
                chk("per1", per[PW +: PW], e1.per);
                chk("amp1", amp[AW +: AW], e1.amp);
                chk("tmo1", tmo[1], e1.tmo);
            end
        end
    end

    function automatic int sq(input int i, input int len, input int a);
        return (i < len / 2) ? a : -a;
    endfunction

    function automatic int sn(input int i, input int len, input int a);
        real r;
        int  v;
        r = a * $sin(6.283185307179586 * (i + 0.5) / len);
        v = $rtoi(r);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    // Present one sample pair for the current cycle, then move to the next cycle.
    task automatic tick(input int a0, input int a1);
        smpl = {a1[15:0], a0[15:0]};
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n, input int a0, input int a1);
        for (int i = 0; i < n; i++) tick(a0, a1);
    endtask

    // One period, high half first; the first sample is a rising crossing when the previous half was low.
    task automatic period2(input int len, input int a0, input int a1, input bit sine1,
                           input bit p0, input int ep0, input int ea0,
                           input bit p1, input int ep1, input int ea1);
        for (int i = 0; i < len; i++) begin
            if (i == 0 && p0) q0.push_back('{cyc + 1, ep0, ea0, 0});
            if (i == 0 && p1) q1.push_back('{cyc + 1, ep1, ea1, 0});
            tick(sq(i, len, a0), sine1 ? sn(i, len, a1) : sq(i, len, a1));
        end
    endtask

    int c;

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        smpl  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_per", per, 0);
        chk("rst_amp", amp, 0);
        chk("rst_vld", vld, 0);
        chk("rst_tmo", tmo, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sub-threshold noise never arms the tracker.
        for (int i = 0; i < 300; i++) tick(int'($urandom_range(20)) - 10, 0);
        chk("noise_per0", per[0 +: PW], 0);
        chk("noise_amp0", amp[0 +: AW], 0);

        // Square +/-1000, period 1000: arm, four periods, result every four periods.
        hold(10, -1000, 0);
        for (int p = 1; p <= 8; p++)
            period2(1000, 1000, 0, 1'b0, p == 5, 1000, 62, 1'b0, 0, 0);
        chk("idle_per1", per[PW +: PW], 0);
        chk("idle_amp1", amp[AW +: AW], 0);

        // Uneven periods 900/1100/1000/1000 average to 1000.
        period2(900,  1000, 0, 1'b0, 1'b1, 1000, 62, 1'b0, 0, 0);
        period2(1100, 1000, 0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        period2(1000, 1000, 0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        period2(1000, 1000, 0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        q0.push_back('{cyc + 1, 1000, 62, 0});
        hold(300, 1000, 0);
        chk("avg_per0", per[0 +: PW], 1000);

        // Clear in the middle of a measurement.
        clr = 1'b1;
        tick(1000, 0);
        clr = 1'b0;
        chk("clr_per", per, 0);
        chk("clr_amp", amp, 0);
        chk("clr_vld", vld, 0);
        chk("clr_tmo", tmo, 0);
        hold(200, 1000, 0);
        hold(500, -2000, 0);
        for (int p = 1; p <= 4; p++)
            period2(800, 2000, 0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);

        // Completes the 800-cycle window, then a stuck-high input runs into the timeout.
        c = cyc;
        q0.push_back('{c + 1, 800, 125, 0});
        q0.push_back('{c + 4096, 4095, 187, 1});
        tick(3000, 0);
        hold(4200, 500, 0);
        chk("tmo0_sticky", tmo[0], 1);
        chk("tmo_per0", per[0 +: PW], 4095);
        chk("tmo_amp0", amp[0 +: AW], 187);

        // Normal result after a timeout clears the flag.
        hold(10, -1000, 0);
        for (int p = 1; p <= 5; p++)
            period2(600, 1000, 0, 1'b0, p == 5, 600, 62, 1'b0, 0, 0);
        chk("tmo0_cleared", tmo[0], 0);
        chk("per0_600", per[0 +: PW], 600);

        // Full-scale sine on ch1 in phase with a square on ch0.
        clr = 1'b1;
        tick(-1000, -32768);
        clr = 1'b0;
        chk("clr2_per", per, 0);
        chk("clr2_tmo", tmo, 0);
        hold(10, -1000, -32768);
        for (int p = 1; p <= 4; p++)
            period2(1000, 1000, 33000, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        q0.push_back('{cyc + 1, 1000, 62, 0});
        q1.push_back('{cyc + 1, 1000, 2047, 0});
        tick(sq(0, 1000, 1000), sn(0, 1000, 33000));
        @(negedge clk);
        chk("vld_both", vld, 2'b11);
        @(posedge clk);
        #1;
        hold(20, 1000, 20000);
        chk("sat_amp1", amp[AW +: AW], 2047);

        chk("q0_pending", q0.size(), 0);
        chk("q1_pending", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
